// File: rtl/wb_port_arbiter.sv
// Round-robin writeback arbiter: picks one of N_REQ execution units per cycle
// and registers its result into a single register-file write slot.
module wb_port_arbiter #(
    parameter int N_REQ = 3,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*AW-1:0]   req_rd,
    input  logic [N_REQ*XLEN-1:0] req_data,
    output logic [N_REQ-1:0]      req_ready,
    input  logic                  wb_stall,
    input  logic                  flush,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [AW-1:0]         wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic [31:0]           perf_wb_cnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   sel;
    logic            found;
    logic            grant;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    function automatic logic [PW-1:0] wrap_idx(input int v);
        return PW'(v % N_REQ);
    endfunction

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[wrap_idx(int'(ptr) + k)]) begin
                found = 1'b1;
                sel   = wrap_idx(int'(ptr) + k);
            end
        end
    end

    assign grant    = found && !rst && !flush && !wb_stall;
    assign sel_rd   = req_rd[sel*AW +: AW];
    assign sel_data = req_data[sel*XLEN +: XLEN];

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            perf_wb_cnt <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
        end else if (wb_stall) begin
            // Downstream is holding: keep the current slot intact.
            wb_valid <= wb_valid;
        end else if (grant) begin
            ptr         <= wrap_idx(int'(sel) + 1);
            wb_valid    <= 1'b1;
            wb_we       <= (sel_rd != '0);
            wb_rd       <= sel_rd;
            wb_data     <= sel_data;
            perf_wb_cnt <= perf_wb_cnt + 32'd1;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a reference model predicts grants and
// the registered writeback slot, which is queued and checked one cycle later.
module tb_wb_port_arbiter;

    localparam int N  = 3;
    localparam int XL = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_rd;
    logic [N*XL-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            wb_stall;
    logic            flush;
    logic            wb_valid;
    logic            wb_we;
    logic [AW-1:0]   wb_rd;
    logic [XL-1:0]   wb_data;
    logic [31:0]     perf_wb_cnt;

    always #5 clk = ~clk;

    wb_port_arbiter #(.N_REQ(N), .XLEN(XL), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_rd     (req_rd),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wb_stall   (wb_stall),
        .flush      (flush),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .perf_wb_cnt(perf_wb_cnt)
    );

    typedef struct packed {
        logic          v;
        logic          we;
        logic [AW-1:0] rd;
        logic [XL-1:0] d;
        logic [31:0]   cnt;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    int            m_ptr;
    logic          m_v;
    logic          m_we;
    logic [AW-1:0] m_rd;
    logic [XL-1:0] m_d;
    logic [31:0]   m_cnt;
    int            last_gnt;

    task automatic set_req(input int i, input logic [AW-1:0] rd,
                           input logic [XL-1:0] d);
        req_rd[i*AW +: AW]   = rd;
        req_data[i*XL +: XL] = d;
    endtask

    // One clock: check req_ready now, queue the predicted slot, check it after the edge.
    task automatic cycle(input string tag);
        int           g;
        logic [N-1:0] exp_rdy;
        exp_t         e;
        exp_t         got;
        g = -1;
        if (!rst && !flush && !wb_stall) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        #1;
        total++;
        if (req_ready !== exp_rdy) begin
            bad++;
            $display("FAIL %s ready: got %b want %b", tag, req_ready, exp_rdy);
        end
        if (rst) begin
            m_ptr = 0; m_v = 0; m_we = 0; m_rd = '0; m_d = '0; m_cnt = '0;
        end else if (flush) begin
            m_v = 0; m_we = 0;
        end else if (wb_stall) begin
            m_v = m_v;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % N;
            m_v   = 1'b1;
            m_rd  = req_rd[g*AW +: AW];
            m_d   = req_data[g*XL +: XL];
            m_we  = (m_rd != '0);
            m_cnt = m_cnt + 32'd1;
        end else begin
            m_v = 0; m_we = 0;
        end
        last_gnt = g;
        sb.push_back('{m_v, m_we, m_rd, m_d, m_cnt});
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        got = '{wb_valid, wb_we, wb_rd, wb_data, perf_wb_cnt};
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s slot: got v=%b we=%b rd=%0d d=%h cnt=%0d want v=%b we=%b rd=%0d d=%h cnt=%0d",
                     tag, got.v, got.we, got.rd, got.d, got.cnt,
                     e.v, e.we, e.rd, e.d, e.cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; wb_stall = 1'b0;
        req_valid = 3'b111;
        set_req(0, 5'd1, 32'h1000_0001);
        set_req(1, 5'd2, 32'h2000_0002);
        set_req(2, 5'd3, 32'h3000_0003);
        cycle("reset0");
        cycle("reset1");
        total++;
        if ({wb_valid, wb_we, wb_rd, wb_data, perf_wb_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_zero: got v=%b rd=%0d d=%h cnt=%0d want all 0",
                     wb_valid, wb_rd, wb_data, perf_wb_cnt);
        end
    endtask

    task automatic test_round_robin();
        int want[6] = '{0, 1, 2, 0, 1, 2};
        rst = 1'b0;
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            cycle("rr");
            total++;
            if (last_gnt != want[c] || wb_valid !== 1'b1) begin
                bad++;
                $display("FAIL rr_order c=%0d: got gnt=%0d v=%b want gnt=%0d v=1",
                         c, last_gnt, wb_valid, want[c]);
            end
        end
        total++;
        if (perf_wb_cnt !== 32'd6) begin
            bad++;
            $display("FAIL rr_count: got %0d want 6", perf_wb_cnt);
        end
    endtask

    task automatic test_x0();
        logic [31:0] c0;
        c0 = perf_wb_cnt;
        req_valid = 3'b010;
        set_req(1, 5'd0, 32'h0000_DEAD);
        cycle("x0");
        total++;
        if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_rd !== 5'd0 ||
            perf_wb_cnt !== c0 + 32'd1) begin
            bad++;
            $display("FAIL x0_write: got v=%b we=%b rd=%0d cnt=%0d want v=1 we=0 rd=0 cnt=%0d",
                     wb_valid, wb_we, wb_rd, perf_wb_cnt, c0 + 32'd1);
        end
    endtask

    task automatic test_stall();
        logic [31:0] c0;
        req_valid = 3'b001;
        set_req(0, 5'd5, 32'h0000_1234);
        cycle("stall_pre");
        c0 = perf_wb_cnt;
        wb_stall = 1'b1;
        req_valid = 3'b111;
        for (int c = 0; c < 3; c++) cycle("stall");
        total++;
        if (wb_rd !== 5'd5 || wb_data !== 32'h1234 || wb_valid !== 1'b1 ||
            perf_wb_cnt !== c0) begin
            bad++;
            $display("FAIL stall_hold: got rd=%0d d=%h v=%b cnt=%0d want rd=5 d=1234 v=1 cnt=%0d",
                     wb_rd, wb_data, wb_valid, perf_wb_cnt, c0);
        end
        wb_stall = 1'b0;
    endtask

    task automatic test_flush();
        wb_stall = 1'b1;
        flush = 1'b1;
        req_valid = 3'b111;
        cycle("flush");
        total++;
        if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin
            bad++;
            $display("FAIL flush_kill: got v=%b we=%b want 0 0", wb_valid, wb_we);
        end
        wb_stall = 1'b0;
        flush = 1'b0;
        cycle("post_flush");
    endtask

    task automatic test_wrap();
        force dut.perf_wb_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.perf_wb_cnt;
        m_cnt = 32'hFFFF_FFFF;
        req_valid = 3'b001;
        set_req(0, 5'd7, 32'h0BAD_F00D);
        cycle("wrap");
        total++;
        if (perf_wb_cnt !== 32'd0) begin
            bad++;
            $display("FAIL cnt_wrap: got %h want 0", perf_wb_cnt);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 3'b010;
        set_req(1, 5'd9, 32'h9999_0009);
        cycle("mid_pre");
        rst = 1'b1;
        req_valid = 3'b111;
        cycle("mid_rst");
        rst = 1'b0;
        req_valid = 3'b110;
        cycle("mid_post");
        total++;
        if (last_gnt != 1 || wb_rd !== 5'd9) begin
            bad++;
            $display("FAIL reset_mid: got gnt=%0d rd=%0d want gnt=1 rd=9", last_gnt, wb_rd);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 60; c++) begin
            req_valid = N'($urandom_range(0, 7));
            wb_stall  = ($urandom_range(0, 5) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++) begin
                set_req(i, AW'($urandom_range(0, 31)), $urandom);
            end
            cycle("random");
        end
        wb_stall = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_x0();
        test_stall();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL expose parameter N_REQ, default 3, giving the number of writeback requesters (index 0 = ALU, 1 = MUL, 2 = LSU).
REQ-002 The block SHALL expose parameter XLEN, default 32, giving the writeback data width.
REQ-003 The block SHALL expose parameter AW, default 5, giving the destination register address width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, N_REQ bits: per-requester writeback request.
REQ-007 The block SHALL have port req_rd, input, N_REQ*AW bits: per-requester destination register, requester i at slice [i*AW +: AW].
REQ-008 The block SHALL have port req_data, input, N_REQ*XLEN bits: per-requester result, requester i at slice [i*XLEN +: XLEN].
REQ-009 The block SHALL have port req_ready, output, N_REQ bits: one-hot grant; the request is consumed in the cycle where valid and ready are both high.
REQ-010 The block SHALL have port wb_stall, input, 1 bit: downstream hold request.
REQ-011 The block SHALL have port flush, input, 1 bit: pipeline flush.
REQ-012 The block SHALL have port wb_valid, output, 1 bit: registered writeback slot valid.
REQ-013 The block SHALL have port wb_we, output, 1 bit: register-file write enable.
REQ-014 The block SHALL have port wb_rd, output, AW bits: registered destination register.
REQ-015 The block SHALL have port wb_data, output, XLEN bits: registered writeback data.
REQ-016 The block SHALL have port perf_wb_cnt, output, 32 bits: count of granted writebacks.

Function
REQ-017 Arbitration SHALL be round-robin: scan order ptr, ptr+1, ... mod N_REQ; the first index with req_valid high is selected.
REQ-018 req_ready SHALL be combinational: at most one bit high, and only for the selected index, and only when wb_stall=0, flush=0 and rst=0.
REQ-019 On a grant to index i, ptr SHALL become (i+1) mod N_REQ in the next cycle; without a grant, ptr SHALL hold.
REQ-020 On a grant, the next cycle SHALL show wb_valid=1, wb_rd=req_rd[i], wb_data=req_data[i] and wb_we=(req_rd[i]!=0); latency from grant to output is exactly 1 cycle.
REQ-021 A write to x0 SHALL consume the request and drive wb_valid=1 with wb_we=0.
REQ-022 With no grant, wb_stall=0 and flush=0, the next cycle SHALL show wb_valid=0 and wb_we=0; wb_rd and wb_data hold their previous values.
REQ-023 With wb_stall=1 and flush=0, wb_valid, wb_we, wb_rd and wb_data SHALL hold, and no grant SHALL occur.
REQ-024 With flush=1, the next cycle SHALL show wb_valid=0 and wb_we=0, with no grant and ptr held; flush SHALL override wb_stall.
REQ-025 A requester SHALL hold req_valid, req_rd and req_data stable until granted; the arbiter SHALL never grant an index whose req_valid is low.
REQ-026 perf_wb_cnt SHALL increment by 1 per grant, including x0 grants, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-027 Under continuous requests from all requesters, each requester SHALL be granted at least once every N_REQ cycles in which wb_stall=0 and flush=0.

Reset
REQ-028 While rst=1, the next cycle SHALL show wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, perf_wb_cnt=0 and ptr=0, with req_ready=0 during reset.
REQ-029 Reset asserted mid-operation SHALL discard the pending output slot, and the first grant after reset SHALL follow ptr=0 ordering.

Verification
REQ-030 Reset, then req_valid=3'b111 for 6 cycles -> grants in order 0,1,2,0,1,2; wb_valid=1 each cycle from cycle 2; perf_wb_cnt=6.
REQ-031 req_valid[1]=1 with rd=0 and data=0xDEAD -> next cycle wb_valid=1, wb_we=0, wb_rd=0; perf_wb_cnt increments by 1.
REQ-032 wb_valid=1 with wb_rd=5 and wb_data=0x1234, then wb_stall=1 for 3 cycles with req_valid=3'b111 -> outputs hold rd=5 and data=0x1234, req_ready=0, perf_wb_cnt unchanged.
REQ-033 wb_stall=1 and flush=1 together -> next cycle wb_valid=0, wb_we=0, no grant, ptr unchanged.
REQ-034 Force perf_wb_cnt to 0xFFFFFFFF, then issue 1 grant -> perf_wb_cnt=0.
REQ-035 Assert rst mid-stream with ptr=2 -> outputs zero; first grant after reset with req_valid=3'b110 goes to index 1.
